// File: rtl/arcade_input_ctl.sv
// Input conditioning for the game core: PS/2 key decode merged with two pads,
// cabinet routing, and a fixed-width coin pulse with lockout. All outputs registered.
module arcade_input_ctl #(
  parameter int COIN_PULSE_CYC = 4800000,
  parameter int COIN_GAP_CYC   = 2400000
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        cabinet,
  output logic [5:0]  INP0,
  output logic [5:0]  INP1,
  output logic [2:0]  INP2
);
  localparam int CNT_MAX = (COIN_PULSE_CYC > COIN_GAP_CYC) ? COIN_PULSE_CYC : COIN_GAP_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] PULSE_LD = CW'(COIN_PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(COIN_GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, WREL} coin_st_e;

  // Key state: player vectors use the output ordering {trig2,trig1,left,down,right,up}
  logic [5:0] p1_q, p1_d, p2_q, p2_d;
  logic       f1_q, f1_d, f2_q, f2_d, st1_q, st1_d, st2_q, st2_d, c1_q, c1_d, c2_q, c2_d;
  logic       toggle_q, toggle_d;
  logic [5:0] inp0_q, inp0_d, inp1_q, inp1_d;
  logic [1:0] start_q, start_d;
  logic       coin_q, coin_d;
  logic [5:0] p1_m, p2_m;
  logic       raw_coin;

  coin_st_e   st_q;
  logic [CW-1:0] cnt_q;
  logic       pulse_q;

  logic unused_joy;
  assign unused_joy = ^{joystick_0[15:9], joystick_1[15:9]};

  // Pad bits [0]R [1]L [2]D [3]U [4]T1 [5]T2 reordered to the output layout
  function automatic logic [5:0] pad(input logic [5:0] j);
    return {j[5], j[4], j[1], j[2], j[0], j[3]};
  endfunction

  always_comb begin
    p1_d = p1_q; p2_d = p2_q;
    f1_d = f1_q; f2_d = f2_q; st1_d = st1_q; st2_d = st2_q; c1_d = c1_q; c2_d = c2_q;
    toggle_d = ps2_key[10];
    if (ps2_key[10] != toggle_q) begin
      // Arrow keys match on the low byte so the E0 prefix does not matter
      case (ps2_key[7:0])
        8'h75:   p1_d[0] = ps2_key[9];
        8'h74:   p1_d[1] = ps2_key[9];
        8'h72:   p1_d[2] = ps2_key[9];
        8'h6B:   p1_d[3] = ps2_key[9];
        default: ;
      endcase
      case (ps2_key[8:0])
        9'h029:  p1_d[4] = ps2_key[9];
        9'h014:  p1_d[5] = ps2_key[9];
        9'h02D:  p2_d[0] = ps2_key[9];
        9'h034:  p2_d[1] = ps2_key[9];
        9'h02B:  p2_d[2] = ps2_key[9];
        9'h023:  p2_d[3] = ps2_key[9];
        9'h01C:  p2_d[4] = ps2_key[9];
        9'h01B:  p2_d[5] = ps2_key[9];
        9'h005:  f1_d    = ps2_key[9];
        9'h006:  f2_d    = ps2_key[9];
        9'h016:  st1_d   = ps2_key[9];
        9'h01E:  st2_d   = ps2_key[9];
        9'h02E:  c1_d    = ps2_key[9];
        9'h036:  c2_d    = ps2_key[9];
        default: ;
      endcase
    end
  end

  always_comb begin
    p2_m     = p2_q | pad(joystick_1[5:0]);
    p1_m     = p1_q | pad(joystick_0[5:0]) | (cabinet ? 6'd0 : p2_m);
    raw_coin = f1_q | f2_q | c1_q | c2_q | joystick_0[8] | joystick_1[8];
    inp0_d   = p1_m;
    inp1_d   = p2_m;
    start_d  = {f2_q | st2_q | joystick_0[7] | joystick_1[7],
                f1_q | st1_q | joystick_0[6] | joystick_1[6]};
    coin_d   = raw_coin;
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      toggle_q <= ps2_key[10];
      p1_q <= '0; p2_q <= '0;
      f1_q <= 1'b0; f2_q <= 1'b0; st1_q <= 1'b0; st2_q <= 1'b0; c1_q <= 1'b0; c2_q <= 1'b0;
      inp0_q <= '0; inp1_q <= '0; start_q <= '0; coin_q <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
      p1_q <= p1_d; p2_q <= p2_d;
      f1_q <= f1_d; f2_q <= f2_d; st1_q <= st1_d; st2_q <= st2_d; c1_q <= c1_d; c2_q <= c2_d;
      inp0_q <= inp0_d; inp1_q <= inp1_d; start_q <= start_d; coin_q <= coin_d;
    end
  end

  // Coin shaper: one pulse per rise, then a forced gap, then wait for release
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE:  if (raw_coin && !coin_q) begin
                 st_q <= PULSE; cnt_q <= PULSE_LD; pulse_q <= 1'b1;
               end
        PULSE: if (cnt_q == '0) begin
                 st_q <= GAP; cnt_q <= GAP_LD; pulse_q <= 1'b0;
               end else cnt_q <= cnt_q - 1'b1;
        GAP:   if (cnt_q == '0) st_q <= WREL;
               else cnt_q <= cnt_q - 1'b1;
        WREL:  if (!raw_coin) st_q <= IDLE;
      endcase
    end
  end

  assign INP0 = inp0_q;
  assign INP1 = inp1_q;
  assign INP2 = {pulse_q, start_q};
endmodule

// File: tb/tb_arcade_input_ctl.sv
// Bench for arcade_input_ctl: vector table, coin corner sequences, and random
// stimulus against a timeline-based reference model.
module tb_arcade_input_ctl;
  localparam int P = 8;
  localparam int G = 4;

  logic        clk_sys = 1'b0;
  logic        RESET = 1'b1;
  logic [10:0] ps2_key = 11'h400;
  logic [15:0] joystick_0 = '0, joystick_1 = '0;
  logic        cabinet = 1'b0;
  logic [5:0]  INP0, INP1;
  logic [2:0]  INP2;

  int n_chk = 0, n_pass = 0;

  arcade_input_ctl #(.COIN_PULSE_CYC(P), .COIN_GAP_CYC(G)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1), .cabinet(cabinet),
    .INP0(INP0), .INP1(INP1), .INP2(INP2)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: key states by index, coin pulse tracked as a start time
  // 0..5 P1 {up,right,down,left,t1,t2}, 6..11 P2 same, 12 F1 13 F2 14 S1 15 S2 16 C1 17 C2
  bit mk[18];
  int cyc = 0, s_start = -100000;
  bit idle = 1, raw_prev = 0, tog_prev = 0;
  logic [5:0] e0, e1;
  logic [2:0] e2;

  function automatic int keyidx(input logic [8:0] c);
    logic [7:0] lo;
    lo = c[7:0];
    if (lo == 8'h75) return 0;
    if (lo == 8'h74) return 1;
    if (lo == 8'h72) return 2;
    if (lo == 8'h6B) return 3;
    case (c)
      9'h029: return 4;  9'h014: return 5;
      9'h02D: return 6;  9'h034: return 7;  9'h02B: return 8;
      9'h023: return 9;  9'h01C: return 10; 9'h01B: return 11;
      9'h005: return 12; 9'h006: return 13; 9'h016: return 14;
      9'h01E: return 15; 9'h02E: return 16; 9'h036: return 17;
      default: return -1;
    endcase
  endfunction

  function automatic logic [5:0] jmap(input logic [15:0] j);
    logic [5:0] r;
    r[0] = j[3]; r[1] = j[0]; r[2] = j[2]; r[3] = j[1]; r[4] = j[4]; r[5] = j[5];
    return r;
  endfunction

  task automatic model_edge();
    logic [5:0] k1, k2, p1, p2;
    logic st1, st2, raw;
    int idx;
    if (RESET) begin
      foreach (mk[i]) mk[i] = 0;
      e0 = '0; e1 = '0; e2 = '0;
      idle = 1; s_start = -100000; raw_prev = 0; tog_prev = ps2_key[10];
      cyc++;
      return;
    end
    for (int i = 0; i < 6; i++) begin k1[i] = mk[i]; k2[i] = mk[6+i]; end
    p2  = k2 | jmap(joystick_1);
    p1  = k1 | jmap(joystick_0) | (cabinet ? 6'd0 : p2);
    st1 = mk[12] | mk[14] | joystick_0[6] | joystick_1[6];
    st2 = mk[13] | mk[15] | joystick_0[7] | joystick_1[7];
    raw = mk[12] | mk[13] | mk[16] | mk[17] | joystick_0[8] | joystick_1[8];
    if (!idle) begin
      if (cyc > s_start + P + G && !raw) idle = 1;
    end else if (raw && !raw_prev) begin
      s_start = cyc; idle = 0;
    end
    e0 = p1; e1 = p2;
    e2 = {(cyc >= s_start && cyc < s_start + P), st2, st1};
    raw_prev = raw;
    if (ps2_key[10] != tog_prev) begin
      tog_prev = ps2_key[10];
      idx = keyidx(ps2_key[8:0]);
      if (idx >= 0) mk[idx] = ps2_key[9];
    end
    cyc++;
  endtask

  task automatic step(input bit do_chk);
    model_edge();
    @(posedge clk_sys); #1;
    if (do_chk) begin
      chk("rnd_inp0", {2'b0, INP0}, {2'b0, e0});
      chk("rnd_inp1", {2'b0, INP1}, {2'b0, e1});
      chk("rnd_inp2", {5'b0, INP2}, {5'b0, e2});
    end
  endtask

  task automatic key(input bit pr, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pr, code};
  endtask

  // Counts coin-pulse high cycles and rising edges over n cycles
  task automatic coin_watch(input int n, input int rel_at, output int highs, output int rises);
    logic prev;
    prev = INP2[2]; highs = 0; rises = 0;
    for (int i = 0; i < n; i++) begin
      if (i == rel_at) key(1'b0, 9'h036);
      step(1'b0);
      if (INP2[2]) highs++;
      if (INP2[2] && !prev) rises++;
      prev = INP2[2];
    end
  endtask

  typedef struct {
    bit tog; bit pr; logic [8:0] code;
    logic [15:0] j0, j1; bit cab;
    logic [5:0] x0, x1; logic [2:0] x2;
  } vec_t;

  vec_t tbl[14];
  int highs, rises;

  initial begin
    tbl[0]  = '{1, 1, 9'h175, 16'h0000, 16'h0000, 0, 6'b000001, 6'b000000, 3'b000};
    tbl[1]  = '{1, 0, 9'h175, 16'h0000, 16'h0000, 0, 6'b000000, 6'b000000, 3'b000};
    tbl[2]  = '{0, 0, 9'h000, 16'h0000, 16'h0001, 0, 6'b000010, 6'b000010, 3'b000};
    tbl[3]  = '{0, 0, 9'h000, 16'h0000, 16'h0001, 1, 6'b000000, 6'b000010, 3'b000};
    tbl[4]  = '{1, 1, 9'h01C, 16'h0000, 16'h0010, 1, 6'b000000, 6'b010000, 3'b000};
    tbl[5]  = '{1, 0, 9'h01C, 16'h0000, 16'h0010, 1, 6'b000000, 6'b010000, 3'b000};
    tbl[6]  = '{0, 0, 9'h000, 16'h0000, 16'h0000, 1, 6'b000000, 6'b000000, 3'b000};
    tbl[7]  = '{1, 1, 9'h06B, 16'h0000, 16'h0000, 0, 6'b001000, 6'b000000, 3'b000};
    tbl[8]  = '{1, 1, 9'h123, 16'h0000, 16'h0000, 0, 6'b001000, 6'b000000, 3'b000};
    tbl[9]  = '{1, 1, 9'h016, 16'h0000, 16'h0000, 0, 6'b001000, 6'b000000, 3'b001};
    tbl[10] = '{0, 0, 9'h000, 16'h0080, 16'h0000, 0, 6'b001000, 6'b000000, 3'b011};
    tbl[11] = '{1, 0, 9'h016, 16'h0000, 16'h0000, 0, 6'b001000, 6'b000000, 3'b000};
    tbl[12] = '{1, 0, 9'h16B, 16'h0000, 16'h0000, 0, 6'b000000, 6'b000000, 3'b000};
    tbl[13] = '{0, 0, 9'h000, 16'hFE08, 16'h0004, 0, 6'b000101, 6'b000100, 3'b000};

    // Reset with the toggle bit high; release must not create a key event
    for (int i = 0; i < 3; i++) step(1'b0);
    RESET = 1'b0;
    step(1'b0); step(1'b0);
    chk("rst_inp0", {2'b0, INP0}, 8'h00);
    chk("rst_inp1", {2'b0, INP1}, 8'h00);
    chk("rst_inp2", {5'b0, INP2}, 8'h00);

    foreach (tbl[i]) begin
      if (tbl[i].tog) key(tbl[i].pr, tbl[i].code);
      joystick_0 = tbl[i].j0; joystick_1 = tbl[i].j1; cabinet = tbl[i].cab;
      step(1'b0); step(1'b0);
      chk($sformatf("vec%0d_inp0", i), {2'b0, INP0}, {2'b0, tbl[i].x0});
      chk($sformatf("vec%0d_inp1", i), {2'b0, INP1}, {2'b0, tbl[i].x1});
      chk($sformatf("vec%0d_inp2", i), {5'b0, INP2}, {5'b0, tbl[i].x2});
    end
    joystick_0 = '0; joystick_1 = '0;
    for (int i = 0; i < 20; i++) step(1'b0);

    // Held coin: one pulse of P cycles, first high right after the first edge
    joystick_0 = 16'h0100;
    step(1'b0);
    chk("coin_first", {7'b0, INP2[2]}, 8'h01);
    coin_watch(49, -1, highs, rises);
    chk("hold_highs", 8'(highs + 1), 8'(P));
    chk("hold_rises", 8'(rises), 8'd0);
    joystick_0 = '0;
    for (int i = 0; i < 5; i++) step(1'b0);
    joystick_0 = 16'h0100;
    coin_watch(20, -1, highs, rises);
    chk("repress_highs", 8'(highs), 8'(P));
    chk("repress_rises", 8'(rises), 8'd1);
    joystick_0 = '0;
    for (int i = 0; i < 5; i++) step(1'b0);

    // A second coin source rising inside the pulse is ignored
    joystick_0 = 16'h0100;
    step(1'b0);
    joystick_0 = '0;
    key(1'b1, 9'h036);
    coin_watch(30, 15, highs, rises);
    chk("c2_highs", 8'(highs + 1), 8'(P));
    chk("c2_rises", 8'(rises), 8'd0);
    for (int i = 0; i < 5; i++) step(1'b0);

    // Reset at cycle 3 of a pulse drops the coin output on the reset edge
    joystick_0 = 16'h0100;
    step(1'b0); step(1'b0); step(1'b0);
    chk("pre_rst_coin", {7'b0, INP2[2]}, 8'h01);
    RESET = 1'b1;
    step(1'b0);
    chk("mid_rst_inp2", {5'b0, INP2}, 8'h00);
    chk("mid_rst_inp0", {2'b0, INP0}, 8'h00);
    RESET = 1'b0; joystick_0 = '0;
    for (int i = 0; i < 3; i++) step(1'b0);

    // Random phase against the model
    for (int i = 0; i < 600; i++) begin
      logic [8:0] codes [16];
      codes = '{9'h175, 9'h072, 9'h16B, 9'h074, 9'h029, 9'h014, 9'h005, 9'h006,
                9'h016, 9'h01E, 9'h02E, 9'h036, 9'h02D, 9'h01C, 9'h123, 9'h0AA};
      if ($urandom_range(0, 2) == 0) key($urandom_range(0, 1), codes[$urandom_range(0, 15)]);
      if ($urandom_range(0, 3) == 0) begin
        joystick_0 = 16'($urandom) & 16'hFEFF;
        joystick_1 = 16'($urandom) & 16'hFEFF;
        if ($urandom_range(0, 15) == 0) joystick_0[8] = 1'b1;
        if ($urandom_range(0, 15) == 0) joystick_1[8] = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) cabinet = ~cabinet;
      RESET = ($urandom_range(0, 199) == 0);
      step(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
